hub75_bcm_scan: RTL and testbench

HUB75_BCM_SCAN -- requirements
Module: hub75_bcm_scan

---
 rtl/hub75_bcm_scan_if.sv | 25 ++
 rtl/hub75_bcm_scan.sv | 208 ++++++++++++++++++++
 tb/tb_hub75_bcm_scan.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_bcm_scan_if.sv
// Framebuffer read port of the HUB75 scanner: one address per column,
// top and bottom half pixels returned together one clock after rd_en.
interface hub75_bcm_scan_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 12
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data_top;
  logic [DATA_W-1:0] rd_data_bot;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data_top,
    input  rd_data_bot
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data_top,
    output rd_data_bot
  );
endinterface

// File: rtl/hub75_bcm_scan.sv
// HUB75 LED panel scanner with binary-coded modulation: per row pair it shifts
// every bit-plane, latches it, then enables the LEDs for BASE_ON<<plane cycles.
module hub75_bcm_scan #(
  parameter int COLS      = 64,
  parameter int ROW_PAIRS = 32,
  parameter int BPP       = 4,
  parameter int CLK_DIV   = 64,
  parameter int BASE_ON   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  hub75_bcm_scan_if.master                      fb,
  output logic [2:0]                            rgb_top,
  output logic [2:0]                            rgb_bot,
  output logic [$clog2(ROW_PAIRS)-1:0]          row_addr,
  output logic [$clog2(COLS)-1:0]               col_addr,
  output logic [((BPP > 1) ? $clog2(BPP) : 1)-1:0] plane,
  output logic                                  display_clk,
  output logic                                  latch,
  output logic                                  oe_n,
  output logic                                  frame_start,
  output logic                                  busy
);

  localparam int RW     = $clog2(ROW_PAIRS);
  localparam int CW     = $clog2(COLS);
  localparam int PW     = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int SLOT   = 2 * CLK_DIV;
  localparam int MAX_ON = BASE_ON << (BPP - 1);
  localparam int MAX_D  = (SLOT > MAX_ON) ? SLOT : MAX_ON;
  localparam int CNT_W  = $clog2(MAX_D + 1);

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CLK_RISE   = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] CAPTURE    = CNT_W'(1);
  localparam logic [CW-1:0]    COL_LAST   = CW'(COLS - 1);
  localparam logic [RW-1:0]    ROW_LAST   = RW'(ROW_PAIRS - 1);
  localparam logic [PW-1:0]    PLANE_LAST = PW'(BPP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [PW-1:0]      plane_q, plane_d;
  logic [RW+CW-1:0]   rd_addr_q, rd_addr_d;
  logic [2:0]         rgb_top_q, rgb_top_d;
  logic [2:0]         rgb_bot_q, rgb_bot_d;
  logic               rd_en_q, rd_en_d;
  logic               display_clk_q, display_clk_d;
  logic               latch_q, latch_d;
  logic               oe_n_q, oe_n_d;
  logic               frame_start_q, frame_start_d;
  logic               busy_q, busy_d;
  logic               armed_q, armed_d;

  // Last count of the DISPLAY phase for a given plane (on-time doubles per plane).
  function automatic logic [CNT_W-1:0] on_last(input logic [PW-1:0] p);
    return CNT_W'((BASE_ON << p) - 1);
  endfunction

  // Select bit p of each colour field, returned as {R,G,B}.
  function automatic logic [2:0] plane_bits(input logic [3*BPP-1:0] d,
                                            input logic [PW-1:0]    p);
    logic [2:0] b;
    b = 3'b000;
    for (int i = 0; i < BPP; i++) begin
      if (p == PW'(i)) b = {d[2*BPP+i], d[BPP+i], d[i]};
    end
    return b;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    plane_d   = plane_q;
    rgb_top_d = rgb_top_q;
    rgb_bot_d = rgb_bot_q;
    // The first clean edge after reset only arms the scanner, so a scan
    // never starts on the same edge that leaves reset.
    armed_d   = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (enable && armed_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          plane_d = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d = '0;
          if (col_q == COL_LAST) begin
            state_d = LATCH;
            col_d   = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = DISPLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DISPLAY: begin
        if (cnt_q == on_last(plane_q)) begin
          cnt_d = '0;
          if (plane_q != PLANE_LAST) begin
            plane_d = plane_q + 1'b1;
            state_d = SHIFT;
          end else begin
            plane_d = '0;
            if (row_q != ROW_LAST) begin
              row_d   = row_q + 1'b1;
              state_d = SHIFT;
            end else begin
              // Frame boundary is the only place enable is honoured.
              row_d   = '0;
              state_d = enable ? SHIFT : IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data is on the bus during slot cycle 1; register it straight out.
    if (state_q == SHIFT && cnt_q == CAPTURE) begin
      rgb_top_d = plane_bits(fb.rd_data_top, plane_q);
      rgb_bot_d = plane_bits(fb.rd_data_bot, plane_q);
    end

    rd_en_d       = (state_d == SHIFT) && (cnt_d == '0);
    rd_addr_d     = {row_d, col_d};
    display_clk_d = (state_d == SHIFT) && (cnt_d >= CLK_RISE);
    latch_d       = (state_d == LATCH);
    oe_n_d        = (state_d != DISPLAY);
    busy_d        = (state_d != IDLE);
    frame_start_d = (state_d == SHIFT) && (state_q != SHIFT) &&
                    (row_d == '0) && (plane_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      row_q         <= '0;
      col_q         <= '0;
      plane_q       <= '0;
      rd_addr_q     <= '0;
      rgb_top_q     <= '0;
      rgb_bot_q     <= '0;
      rd_en_q       <= 1'b0;
      display_clk_q <= 1'b0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      col_q         <= col_d;
      plane_q       <= plane_d;
      rd_addr_q     <= rd_addr_d;
      rgb_top_q     <= rgb_top_d;
      rgb_bot_q     <= rgb_bot_d;
      rd_en_q       <= rd_en_d;
      display_clk_q <= display_clk_d;
      latch_q       <= latch_d;
      oe_n_q        <= oe_n_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      armed_q       <= armed_d;
    end
  end

  assign fb.rd_en     = rd_en_q;
  assign fb.rd_addr   = rd_addr_q;
  assign rgb_top      = rgb_top_q;
  assign rgb_bot      = rgb_bot_q;
  assign row_addr     = row_q;
  assign col_addr     = col_q;
  assign plane        = plane_q;
  assign display_clk  = display_clk_q;
  assign latch        = latch_q;
  assign oe_n         = oe_n_q;
  assign frame_start  = frame_start_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Scoreboard bench for hub75_bcm_scan: a 4x2, 2-bit instance driven through
// full frames, enable drop and reset, plus a 1-bit instance for timing.
module tb_hub75_bcm_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic enable;
  logic en_b;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  hub75_bcm_scan_if #(.ADDR_W(3), .DATA_W(6)) fb_a ();
  hub75_bcm_scan_if #(.ADDR_W(3), .DATA_W(3)) fb_b ();

  logic [2:0] rgb_top, rgb_bot;
  logic [0:0] row_addr;
  logic [1:0] col_addr;
  logic [0:0] plane;
  logic       display_clk, latch, oe_n, frame_start, busy;

  logic [2:0] rgb_top_b, rgb_bot_b;
  logic [0:0] row_addr_b;
  logic [1:0] col_addr_b;
  logic [0:0] plane_b;
  logic       display_clk_b, latch_b, oe_n_b, frame_start_b, busy_b;

  hub75_bcm_scan #(.COLS(4), .ROW_PAIRS(2), .BPP(2), .CLK_DIV(3), .BASE_ON(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fb(fb_a),
    .rgb_top(rgb_top), .rgb_bot(rgb_bot), .row_addr(row_addr), .col_addr(col_addr),
    .plane(plane), .display_clk(display_clk), .latch(latch), .oe_n(oe_n),
    .frame_start(frame_start), .busy(busy)
  );

  hub75_bcm_scan #(.COLS(4), .ROW_PAIRS(2), .BPP(1), .CLK_DIV(3), .BASE_ON(1)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .fb(fb_b),
    .rgb_top(rgb_top_b), .rgb_bot(rgb_bot_b), .row_addr(row_addr_b), .col_addr(col_addr_b),
    .plane(plane_b), .display_clk(display_clk_b), .latch(latch_b), .oe_n(oe_n_b),
    .frame_start(frame_start_b), .busy(busy_b)
  );

  typedef struct {
    logic [2:0] addr;
    logic       pl;
    logic [2:0] top;
    logic [2:0] bot;
  } item_t;

  item_t      sb_q[$];
  int         oe_q[$];
  logic [5:0] mem_top [8];
  logic [2:0] exp_top [2][8];

  int  overlap = 0;
  int  b_plane_bad = 0;
  int  b_periods = 0;
  int  oe_len = 0, latch_len = 0, fs_prev = 0;
  bit  fs_valid = 1'b0;
  int  len_b = 0, prev_b = 0;
  bit  v_b = 1'b0;
  item_t it;
  logic       pend;
  logic [2:0] pa;
  int  n;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input bit partial);
    item_t e;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 2; p++) begin
        if (!partial || (r == 0 && p == 0)) begin
          for (int c = 0; c < 4; c++) begin
            e.addr = 3'(r * 4 + c);
            e.pl   = 1'(p);
            e.top  = exp_top[p][r*4+c];
            e.bot  = ~exp_top[p][r*4+c];
            sb_q.push_back(e);
          end
          oe_q.push_back(partial ? 2 : (4 << p));
        end
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_oe_n"}, oe_n, 1);
    chk({tag, "_rd_en"}, fb_a.rd_en, 0);
    chk({tag, "_rd_addr"}, fb_a.rd_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_latch"}, latch, 0);
    chk({tag, "_display_clk"}, display_clk, 0);
    chk({tag, "_rgb_top"}, rgb_top, 0);
    chk({tag, "_rgb_bot"}, rgb_bot, 0);
    chk({tag, "_row_addr"}, row_addr, 0);
    chk({tag, "_col_addr"}, col_addr, 0);
    chk({tag, "_plane"}, plane, 0);
  endtask

  initial forever @(posedge clk) cyc++;

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  // Framebuffer model: valid data only in the cycle after rd_en, complemented otherwise.
  initial begin
    pend = 1'b0;
    pa   = '0;
    fb_a.rd_data_top = '0;
    fb_a.rd_data_bot = '0;
    fb_b.rd_data_top = '0;
    fb_b.rd_data_bot = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        fb_a.rd_data_top = mem_top[pa];
        fb_a.rd_data_bot = ~mem_top[pa];
      end else if (fb_a.rd_en) begin
        fb_a.rd_data_top = ~mem_top[fb_a.rd_addr];
        fb_a.rd_data_bot = mem_top[fb_a.rd_addr];
      end else begin
        fb_a.rd_data_top = ~fb_a.rd_data_top;
        fb_a.rd_data_bot = ~fb_a.rd_data_bot;
      end
      pend = fb_a.rd_en;
      pa   = fb_a.rd_addr;
    end
  end

  // Column-slot monitor: pops one expected read per rd_en pulse.
  initial forever begin
    @(negedge clk);
    if (fb_a.rd_en) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", sb_q.size(), 1);
      end else begin
        it = sb_q.pop_front();
        chk("rd_addr", fb_a.rd_addr, it.addr);
        chk("row_addr", row_addr, it.addr[2]);
        chk("col_addr", col_addr, it.addr[1:0]);
        chk("plane", plane, it.pl);
        @(negedge clk);
        chk("rd_en_width", fb_a.rd_en, 0);
        @(negedge clk);
        chk("rgb_top_c2", rgb_top, it.top);
        chk("rgb_bot_c2", rgb_bot, it.bot);
        chk("dclk_c2", display_clk, 0);
        @(negedge clk);
        chk("rgb_top_c3", rgb_top, it.top);
        chk("dclk_c3", display_clk, 1);
      end
    end
  end

  // Panel timing monitor for the main instance.
  initial forever begin
    @(negedge clk);
    if (!oe_n) oe_len++;
    else if (oe_len > 0) begin
      if (oe_q.size() == 0) chk("oe_underflow", oe_q.size(), 1);
      else chk("oe_len", oe_len, oe_q.pop_front());
      oe_len = 0;
    end
    if (latch) latch_len++;
    else if (latch_len > 0) begin
      chk("latch_len", latch_len, 3);
      latch_len = 0;
    end
    if (!oe_n && (display_clk || latch)) overlap++;
    if (latch && display_clk) overlap++;
    if (frame_start) begin
      if (fs_valid) chk("frame_period", cyc - fs_prev, 132);
      fs_prev  = cyc;
      fs_valid = 1'b1;
    end
    if (!busy) fs_valid = 1'b0;
  end

  // Timing monitor for the single-plane instance.
  initial forever begin
    @(negedge clk);
    if (!oe_n_b) len_b++;
    else if (len_b > 0) begin
      chk("b_oe_len", len_b, 1);
      len_b = 0;
    end
    if (plane_b != 1'b0) b_plane_bad++;
    if (frame_start_b) begin
      if (v_b) begin
        chk("b_frame_period", cyc - prev_b, 56);
        b_periods++;
      end
      prev_b = cyc;
      v_b    = 1'b1;
    end
    if (!busy_b) v_b = 1'b0;
  end

  initial begin
    mem_top    = '{6'b100111, 6'b000000, 6'b111111, 6'b011000,
                   6'b101010, 6'b010101, 6'b110001, 6'b001110};
    exp_top[0] = '{3'b011, 3'b000, 3'b111, 3'b100, 3'b000, 3'b111, 3'b101, 3'b010};
    exp_top[1] = '{3'b101, 3'b000, 3'b111, 3'b010, 3'b111, 3'b000, 3'b100, 3'b011};
    rst    = 1'b0;
    enable = 1'b1;
    en_b   = 1'b1;

    repeat (4) @(negedge clk);
    check_reset("rst0");

    push_frame(1'b0);
    push_frame(1'b0);
    push_frame(1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_e1_busy", busy, 0);
    chk("rel_e1_fs", frame_start, 0);
    @(negedge clk);
    chk("rel_e2_fs", frame_start, 1);
    chk("rel_e2_busy", busy, 1);

    // Drop enable inside row 0, plane 1 of the third frame.
    repeat (264 + 40) @(negedge clk);
    enable = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_latency", n, 92);
    chk("idle_busy", busy, 0);
    chk("idle_oe_n", oe_n, 1);
    chk("idle_row", row_addr, 0);
    chk("idle_plane", plane, 0);

    push_frame(1'b1);
    enable = 1'b1;
    @(negedge clk);
    chk("idle_start_fs", frame_start, 1);
    n = 0;
    while (oe_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("display_reached", n, 27);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("rst1");

    push_frame(1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel2_e1_busy", busy, 0);
    @(negedge clk);
    chk("rel2_e2_fs", frame_start, 1);
    chk("rel2_e2_rd_en", fb_a.rd_en, 1);
    chk("rel2_e2_rd_addr", fb_a.rd_addr, 0);
    enable = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_latency2", n, 132);

    repeat (5) @(negedge clk);
    chk("sb_left", sb_q.size(), 0);
    chk("oe_left", oe_q.size(), 0);
    chk("ctrl_overlap", overlap, 0);
    chk("b_periods_seen", int'(b_periods > 0), 1);
    chk("b_plane_nonzero", b_plane_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
